// File: rtl/mealy_detector_scheduler.sv
// mealy_detector_scheduler
// Round-robin scheduler that shares one serial Mealy sequence detector
// (patterns 0111, 1001, 1110 over 4-bit frames) among N requesters.
// A granted frame is latched, shifted MSB-first into the detector, and the
// detector verdict is returned on a one-cycle done pulse with the
// requester index. A saturating counter tallies matching frames.
//
// Handshake: a requester raises req[i] with frame[4i+3:4i] and holds both
// until it observes done=1 with done_id==i. gnt is registered, one-hot,
// and spans the grant edge through the RESP cycle. The frame is captured at
// the grant edge, so later frame changes are ignored. Dropping req after the
// grant does not abort the transaction. A req still high in the IDLE cycle
// after RESP counts as a new request.

module mealy_detector_scheduler #(
  parameter int N     = 4,
  parameter int CNT_W = 8,
  parameter int IDW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [4*N-1:0]   frame,
  output logic [N-1:0]     gnt,
  output logic             done,
  output logic             match,
  output logic [IDW-1:0]   done_id,
  output logic [CNT_W-1:0] match_cnt,
  output logic             det_in,
  output logic             det_rst_n,
  input  logic             det_dec,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [3:0]       sh_q, sh_d;
  logic [1:0]       bit_q, bit_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             win_valid;
  logic [IDW-1:0]   win_idx;
  logic [3:0]       win_frame;

  // Reduce an index sum back into the 0..N-1 requester range.
  function automatic logic [IDW-1:0] wrap_idx(input int v);
    return IDW'(v % N);
  endfunction

  // Round-robin search: first requester at or above the pointer, wrapping.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < N; off++) begin
      if (!win_valid && req[wrap_idx(int'(ptr_q) + off)]) begin
        win_valid = 1'b1;
        win_idx   = wrap_idx(int'(ptr_q) + off);
      end
    end
  end

  // Frame of the current round-robin winner, latched at the grant edge.
  always_comb begin
    win_frame = frame[int'(win_idx)*4 +: 4];
  end

  // Next-state logic: arbitration in IDLE, serialization in SHIFT,
  // verdict hand-back and counter update in RESP.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    match_d = match_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          gnt_d   = N'(1) << win_idx;
          sh_d    = win_frame;
          bit_d   = 2'd0;
          id_d    = win_idx;
          ptr_d   = wrap_idx(int'(win_idx) + 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_d  = {sh_q[2:0], 1'b0};
        bit_d = bit_q + 2'd1;
        // The detector's Mealy output is only meaningful on its 4th bit.
        if (bit_q == 2'd3) begin
          match_d = det_dec;
          state_d = RESP;
        end
      end
      RESP: begin
        if (match_q && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode; the detector is held cleared whenever we are not shifting,
  // so every SHIFT phase starts at detector count 0.
  always_comb begin
    gnt         = gnt_q;
    done        = (state_q == RESP);
    match       = (state_q == RESP) && match_q;
    done_id     = (state_q == RESP) ? id_q : '0;
    match_cnt   = cnt_q;
    det_in      = (state_q == SHIFT) && sh_q[3];
    det_rst_n   = !rst && (state_q == SHIFT);
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_mealy_detector_scheduler.sv
// Testbench for mealy_detector_scheduler: directed vectors against two
// instances (default CNT_W=8, and CNT_W=2 for counter saturation), each
// paired with a behavioral model of the shared serial Mealy detector.

module tb_mealy_detector_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- instance A (CNT_W=8) ----------------
  logic [3:0]  req_a;
  logic [15:0] frame_a;
  logic [3:0]  gnt_a;
  logic        done_a, match_a, det_in_a, det_rst_n_a, det_dec_a;
  logic [1:0]  id_a, dbg_a;
  logic [7:0]  cnt_a;

  mealy_detector_scheduler #(.N(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .frame(frame_a), .gnt(gnt_a),
    .done(done_a), .match(match_a), .done_id(id_a), .match_cnt(cnt_a),
    .det_in(det_in_a), .det_rst_n(det_rst_n_a), .det_dec(det_dec_a),
    .dbg_state_o(dbg_a)
  );

  // ---------------- instance B (CNT_W=2) ----------------
  logic [3:0]  req_b;
  logic [15:0] frame_b;
  logic [3:0]  gnt_b;
  logic        done_b, match_b, det_in_b, det_rst_n_b, det_dec_b;
  logic [1:0]  id_b, dbg_b;
  logic [1:0]  cnt_b;

  mealy_detector_scheduler #(.N(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .frame(frame_b), .gnt(gnt_b),
    .done(done_b), .match(match_b), .done_id(id_b), .match_cnt(cnt_b),
    .det_in(det_in_b), .det_rst_n(det_rst_n_b), .det_dec(det_dec_b),
    .dbg_state_o(dbg_b)
  );

  // ---------------- detector models ----------------
  // Free-running 4-cycle frame counter with synchronous clear; the Mealy
  // output fires on the 4th bit when the last 3 bits plus the live bit match.
  function automatic logic pat_hit(input logic [3:0] w);
    return (w == 4'b0111) || (w == 4'b1001) || (w == 4'b1110);
  endfunction

  logic [1:0] dcnt_a, dcnt_b;
  logic [2:0] dhist_a, dhist_b;

  always @(posedge clk) begin
    if (!det_rst_n_a) begin
      dcnt_a  <= 2'd0;
      dhist_a <= 3'd0;
    end else begin
      dcnt_a  <= dcnt_a + 2'd1;
      dhist_a <= {dhist_a[1:0], det_in_a};
    end
  end

  always @(posedge clk) begin
    if (!det_rst_n_b) begin
      dcnt_b  <= 2'd0;
      dhist_b <= 3'd0;
    end else begin
      dcnt_b  <= dcnt_b + 2'd1;
      dhist_b <= {dhist_b[1:0], det_in_b};
    end
  end

  assign det_dec_a = det_rst_n_a && (dcnt_a == 2'd3) && pat_hit({dhist_a, det_in_a});
  assign det_dec_b = det_rst_n_b && (dcnt_b == 2'd3) && pat_hit({dhist_b, det_in_b});

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int exp_cnt_b = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one step after the grant edge of instance A; leaves one step
  // into the IDLE cycle following RESP.
  task automatic run_txn(input logic [3:0] g, input logic [3:0] bits,
                         input logic m, input logic [1:0] id);
    for (int k = 0; k < 4; k++) begin
      check_eq("shift_gnt", 32'(gnt_a), 32'(g));
      check_eq("shift_det_in", 32'(det_in_a), 32'(bits[3-k]));
      check_eq("shift_det_rst_n", 32'(det_rst_n_a), 1);
      check_eq("shift_done", 32'(done_a), 0);
      tick();
    end
    check_eq("resp_done", 32'(done_a), 1);
    check_eq("resp_match", 32'(match_a), 32'(m));
    check_eq("resp_done_id", 32'(id_a), 32'(id));
    check_eq("resp_gnt", 32'(gnt_a), 32'(g));
    check_eq("resp_det_rst_n", 32'(det_rst_n_a), 0);
    check_eq("resp_det_in", 32'(det_in_a), 0);
    if (m && exp_cnt < 255) exp_cnt++;
    exp_q.push_back(32'(exp_cnt));
    tick();
    check_eq("idle_done", 32'(done_a), 0);
    check_eq("idle_gnt", 32'(gnt_a), 0);
    check_eq("idle_match", 32'(match_a), 0);
    check_eq("idle_done_id", 32'(id_a), 0);
    check_eq("idle_det_rst_n", 32'(det_rst_n_a), 0);
    check_eq("idle_match_cnt", 32'(cnt_a), exp_q.pop_front());
  endtask

  // ---------------- stimulus tables ----------------
  logic [3:0] s2_frame [3] = '{4'b0101, 4'b1001, 4'b1110};
  logic       s2_match [3] = '{1'b0, 1'b1, 1'b1};
  logic [3:0] s5_frame [7] = '{4'b0111, 4'b1001, 4'b1110, 4'b0111,
                               4'b1001, 4'b1110, 4'b0111};

  initial begin
    rst = 1'b1;
    req_a = '0; frame_a = '0;
    req_b = '0; frame_b = '0;
    tick();
    tick();

    // Reset state
    check_eq("rst_gnt", 32'(gnt_a), 0);
    check_eq("rst_done", 32'(done_a), 0);
    check_eq("rst_match", 32'(match_a), 0);
    check_eq("rst_done_id", 32'(id_a), 0);
    check_eq("rst_match_cnt", 32'(cnt_a), 0);
    check_eq("rst_det_in", 32'(det_in_a), 0);
    check_eq("rst_det_rst_n", 32'(det_rst_n_a), 0);
    rst = 1'b0;

    // Single requester 0 with 0111 -> match
    req_a = 4'b0001;
    frame_a[3:0] = 4'b0111;
    tick();
    run_txn(4'b0001, 4'b0111, 1'b1, 2'd0);
    req_a = 4'b0000;

    // Requester 2, three frames back to back with req held
    req_a = 4'b0100;
    for (int j = 0; j < 3; j++) begin
      frame_a[11:8] = s2_frame[j];
      tick();
      run_txn(4'b0100, s2_frame[j], s2_match[j], 2'd2);
    end
    req_a = 4'b0000;

    // All four requesting: rotation 0,1,2,3,0 from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    check_eq("rst2_match_cnt", 32'(cnt_a), 0);
    req_a = 4'b1111;
    frame_a = 16'hEEEE;
    for (int i = 0; i < 5; i++) begin
      tick();
      run_txn(4'(1 << (i % 4)), 4'b1110, 1'b1, 2'(i % 4));
    end
    req_a = 4'b0000;

    // Reset on the 3rd SHIFT cycle of requester 1
    req_a = 4'b0010;
    frame_a[7:4] = 4'b1001;
    tick();
    check_eq("abort_gnt", 32'(gnt_a), 32'(4'b0010));
    tick();
    tick();
    check_eq("abort_pre_det_rst_n", 32'(det_rst_n_a), 1);
    rst = 1'b1;
    #1;
    check_eq("abort_gnt0", 32'(gnt_a), 0);
    check_eq("abort_done", 32'(done_a), 0);
    check_eq("abort_det_in", 32'(det_in_a), 0);
    check_eq("abort_det_rst_n", 32'(det_rst_n_a), 0);
    check_eq("abort_match_cnt", 32'(cnt_a), 0);
    exp_cnt = 0;
    tick();
    check_eq("abort_no_done", 32'(done_a), 0);
    rst = 1'b0;
    req_a = 4'b1010;
    frame_a[15:12] = 4'b0111;
    tick();
    run_txn(4'b0010, 4'b1001, 1'b1, 2'd1);
    req_a = 4'b1000;
    tick();
    run_txn(4'b1000, 4'b0111, 1'b1, 2'd3);
    req_a = 4'b0000;

    // CNT_W=2 saturation, frame scrambled mid-SHIFT
    req_b = 4'b0001;
    for (int t = 0; t < 7; t++) begin
      frame_b[3:0] = s5_frame[t];
      tick();
      tick();
      frame_b[3:0] = ~s5_frame[t];
      tick();
      tick();
      tick();
      check_eq("sat_done", 32'(done_b), 1);
      check_eq("sat_match", 32'(match_b), 1);
      check_eq("sat_gnt", 32'(gnt_b), 32'(4'b0001));
      if (exp_cnt_b < 3) exp_cnt_b++;
      tick();
      check_eq("sat_match_cnt", 32'(cnt_b), 32'(exp_cnt_b));
    end
    req_b = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
